// File: rtl/sha3_state_loader.sv
// Keccak-f[1600] state loader: packs an IN_WIDTH word stream into the rate lanes and strobes the full state to the theta stage.
// Build option: SHA3_LOADER_BYTESWAP_EN byte-reverses each accepted word before it is stored.
module sha3_state_loader #(
    parameter int IN_WIDTH   = 64,
    parameter int RATE_LANES = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] idata,
    input  logic                ivalid,
    output logic                iready,
    input  logic                iabort,
    input  logic                go,
    output logic                full,
    output logic                sample,
    output logic [4:0][63:0]    osa,
    output logic [4:0][63:0]    osb,
    output logic [4:0][63:0]    osc,
    output logic [4:0][63:0]    osd,
    output logic [4:0][63:0]    ose
);

    localparam int WORDS = RATE_LANES * 64 / IN_WIDTH;

    if (IN_WIDTH != 64 && IN_WIDTH != 32) begin : g_bad_width
        $error("sha3_state_loader: IN_WIDTH must be 64 or 32, got %0d", IN_WIDTH);
    end
    if (RATE_LANES < 1 || RATE_LANES > 25) begin : g_bad_rate
        $error("sha3_state_loader: RATE_LANES must be 1..25, got %0d", RATE_LANES);
    end

    typedef enum logic [1:0] {
        S_FILL,
        S_FULL,
        S_EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [24:0][63:0] lane_q, lane_d;
    logic [IN_WIDTH-1:0] word;
    logic [63:0]      word64;
    logic [4:0]       lane_idx;

`ifdef SHA3_LOADER_BYTESWAP_EN
    function automatic logic [IN_WIDTH-1:0] byte_rev(input logic [IN_WIDTH-1:0] w);
        logic [IN_WIDTH-1:0] r;
        for (int b = 0; b < IN_WIDTH / 8; b++) begin
            r[8*b +: 8] = w[IN_WIDTH-8-8*b +: 8];
        end
        return r;
    endfunction

    always_comb word = byte_rev(idata);
`else
    always_comb word = idata;
`endif

    always_comb begin
        word64   = 64'(word);
        lane_idx = (IN_WIDTH == 64) ? cnt_q[4:0] : cnt_q[5:1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        iready  = 1'b0;
        full    = 1'b0;
        sample  = 1'b0;
        case (state_q)
            S_FILL: begin
                // held low while rst_n is asserted so the sender never sees a ready during reset
                iready = rst_n;
                if (iabort) begin
                    cnt_d  = '0;
                    lane_d = '0;
                end else if (ivalid) begin
                    if (IN_WIDTH == 64) begin
                        lane_d[lane_idx] = word64;
                    end else if (cnt_q[0]) begin
                        lane_d[lane_idx][63:32] = word64[31:0];
                    end else begin
                        lane_d[lane_idx][31:0] = word64[31:0];
                    end
                    if (cnt_q == 6'(WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FULL;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_FULL: begin
                full = 1'b1;
                if (iabort) begin
                    cnt_d   = '0;
                    lane_d  = '0;
                    state_d = S_FILL;
                end else if (go) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                sample  = 1'b1;
                state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
        // capacity lanes are pinned to zero so their flops reduce to constants
        for (int i = 0; i < 25; i++) begin
            if (i >= RATE_LANES) lane_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        for (int x = 0; x < 5; x++) begin
            osa[x] = lane_q[x];
            osb[x] = lane_q[5 + x];
            osc[x] = lane_q[10 + x];
            osd[x] = lane_q[15 + x];
            ose[x] = lane_q[20 + x];
        end
    end

endmodule

// File: tb/tb_sha3_state_loader.sv
// Self-checking bench for sha3_state_loader: a 64-bit and a 32-bit instance driven with random blocks against a lane-array model.
// Honours SHA3_LOADER_BYTESWAP_EN in the model when the build defines it.
module tb_sha3_state_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] d64 = '0;
    logic v64 = 1'b0, ab64 = 1'b0, go64 = 1'b0;
    logic r64, full64, smp64;
    logic [4:0][63:0] a64, b64, c64, dd64, e64;

    logic [31:0] d32 = '0;
    logic v32 = 1'b0, ab32 = 1'b0, go32 = 1'b0;
    logic r32, full32, smp32;
    logic [4:0][63:0] a32, b32, c32, dd32, e32;

    sha3_state_loader #(.IN_WIDTH(64), .RATE_LANES(17)) dut64 (
        .clk(clk), .rst_n(rst_n), .idata(d64), .ivalid(v64), .iready(r64),
        .iabort(ab64), .go(go64), .full(full64), .sample(smp64),
        .osa(a64), .osb(b64), .osc(c64), .osd(dd64), .ose(e64)
    );

    sha3_state_loader #(.IN_WIDTH(32), .RATE_LANES(17)) dut32 (
        .clk(clk), .rst_n(rst_n), .idata(d32), .ivalid(v32), .iready(r32),
        .iabort(ab32), .go(go32), .full(full32), .sample(smp32),
        .osa(a32), .osb(b32), .osc(c32), .osd(dd32), .ose(e32)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_lane [25];
    logic [63:0] wq [$];

    function automatic logic [63:0] lane64(input int i);
        case (i / 5)
            0: return a64[i % 5];
            1: return b64[i % 5];
            2: return c64[i % 5];
            3: return dd64[i % 5];
            default: return e64[i % 5];
        endcase
    endfunction

    function automatic logic [63:0] lane32(input int i);
        case (i / 5)
            0: return a32[i % 5];
            1: return b32[i % 5];
            2: return c32[i % 5];
            3: return dd32[i % 5];
            default: return e32[i % 5];
        endcase
    endfunction

    // Expected state: words land in lane order, 32-bit words low half first, capacity lanes zero.
    function automatic void build_model(input int width);
        logic [63:0] w;
        logic [31:0] h;
        for (int i = 0; i < 25; i++) exp_lane[i] = '0;
        for (int k = 0; k < wq.size(); k++) begin
            if (width == 64) begin
                w = wq[k];
`ifdef SHA3_LOADER_BYTESWAP_EN
                w = {<<8{w}};
`endif
                exp_lane[k] = w;
            end else begin
                h = wq[k][31:0];
`ifdef SHA3_LOADER_BYTESWAP_EN
                h = {<<8{h}};
`endif
                exp_lane[k / 2] = exp_lane[k / 2] | ({32'h0, h} << (32 * (k % 2)));
            end
        end
    endfunction

    function automatic void rand_block(input int nwords);
        wq.delete();
        for (int k = 0; k < nwords; k++) wq.push_back({$urandom(), $urandom()});
    endfunction

    task automatic put64(input logic [63:0] w);
        logic acc;
        repeat ($urandom_range(0, 2)) begin
            d64 = {$urandom(), $urandom()};
            @(posedge clk); #1;
        end
        d64 = w;
        v64 = 1'b1;
        for (int t = 0; ; t++) begin
            acc = r64;
            @(posedge clk); #1;
            if (acc) break;
            if (t > 50) begin
                n_cmp++; n_err++;
                $display("FAIL put64_timeout: iready=%0b required 1", r64);
                break;
            end
        end
        v64 = 1'b0;
        d64 = {$urandom(), $urandom()};
    endtask

    task automatic put32(input logic [31:0] w);
        logic acc;
        repeat ($urandom_range(0, 2)) begin
            d32 = $urandom();
            @(posedge clk); #1;
        end
        d32 = w;
        v32 = 1'b1;
        for (int t = 0; ; t++) begin
            acc = r32;
            @(posedge clk); #1;
            if (acc) break;
            if (t > 50) begin
                n_cmp++; n_err++;
                $display("FAIL put32_timeout: iready=%0b required 1", r32);
                break;
            end
        end
        v32 = 1'b0;
        d32 = $urandom();
    endtask

    task automatic send64();
        for (int k = 0; k < wq.size(); k++) put64(wq[k]);
    endtask

    task automatic send32();
        for (int k = 0; k < wq.size(); k++) put32(wq[k][31:0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({r64, full64, smp64, r32, full32, smp32} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 000000", {r64, full64, smp64, r32, full32, smp32});
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== 64'h0 || lane32(i) !== 64'h0) begin
                n_err++;
                $display("FAIL reset_lane%0d: got %h/%h required 0", i, lane64(i), lane32(i));
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (r64 !== 1'b1 || r32 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_iready: got %b%b required 11", r64, r32);
        end
    endtask

    task automatic test_fill64();
        wq.delete();
        for (int k = 0; k < 17; k++) wq.push_back(64'(k + 1));
        build_model(64);
        go64 = 1'b1;
        send64();
        n_cmp++;
        if ({full64, r64, smp64} !== 3'b100) begin
            n_err++;
            $display("FAIL fill64_after_last: full/iready/sample=%b required 100", {full64, r64, smp64});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (smp64 !== 1'b1) begin
            n_err++;
            $display("FAIL fill64_sample: got %b required 1", smp64);
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== exp_lane[i]) begin
                n_err++;
                $display("FAIL fill64_lane%0d: got %h required %h", i, lane64(i), exp_lane[i]);
            end
        end
`ifndef SHA3_LOADER_BYTESWAP_EN
        n_cmp++;
        if (a64[0] !== 64'd1 || a64[4] !== 64'd5 || dd64[1] !== 64'd17 || dd64[2] !== 64'd0) begin
            n_err++;
            $display("FAIL fill64_direct: osa0=%h osa4=%h osd1=%h osd2=%h required 1,5,17,0", a64[0], a64[4], dd64[1], dd64[2]);
        end
`endif
        @(posedge clk); #1;
        n_cmp++;
        if ({smp64, r64, full64} !== 3'b010) begin
            n_err++;
            $display("FAIL fill64_after_sample: sample/iready/full=%b required 010", {smp64, r64, full64});
        end
        go64 = 1'b0;
    endtask

    task automatic test_fill32();
        wq.delete();
        for (int k = 0; k < 34; k++) wq.push_back(64'(k));
        build_model(32);
        go32 = 1'b1;
        send32();
        n_cmp++;
        if (r32 !== 1'b0 || full32 !== 1'b1) begin
            n_err++;
            $display("FAIL fill32_after_last: iready=%b full=%b required 0 1", r32, full32);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (smp32 !== 1'b1 || r32 !== 1'b0) begin
            n_err++;
            $display("FAIL fill32_sample: sample=%b iready=%b required 1 0", smp32, r32);
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane32(i) !== exp_lane[i]) begin
                n_err++;
                $display("FAIL fill32_lane%0d: got %h required %h", i, lane32(i), exp_lane[i]);
            end
        end
`ifndef SHA3_LOADER_BYTESWAP_EN
        n_cmp++;
        if (a32[0] !== 64'h00000001_00000000 || dd32[1] !== 64'h00000021_00000020) begin
            n_err++;
            $display("FAIL fill32_direct: osa0=%h osd1=%h required 0000000100000000 0000002100000020", a32[0], dd32[1]);
        end
`endif
        @(posedge clk); #1;
        n_cmp++;
        if (smp32 !== 1'b0 || r32 !== 1'b1) begin
            n_err++;
            $display("FAIL fill32_after_sample: sample=%b iready=%b required 0 1", smp32, r32);
        end
        go32 = 1'b0;
    endtask

    task automatic test_go_hold();
        rand_block(17);
        build_model(64);
        go64 = 1'b0;
        send64();
        v64 = 1'b1;
        d64 = {$urandom(), $urandom()};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({full64, r64, smp64} !== 3'b100) begin
                n_err++;
                $display("FAIL hold_cycle%0d: full/iready/sample=%b required 100", c, {full64, r64, smp64});
            end
        end
        v64 = 1'b0;
        go64 = 1'b1;
        @(posedge clk); #1;
        go64 = 1'b0;
        n_cmp++;
        if (smp64 !== 1'b1) begin
            n_err++;
            $display("FAIL hold_go_sample: got %b required 1", smp64);
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== exp_lane[i]) begin
                n_err++;
                $display("FAIL hold_lane%0d: got %h required %h", i, lane64(i), exp_lane[i]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (smp64 !== 1'b0) begin
            n_err++;
            $display("FAIL hold_single_strobe: got %b required 0", smp64);
        end
    endtask

    task automatic test_abort();
        rand_block(5);
        go64 = 1'b0;
        send64();
        d64 = {$urandom(), $urandom()};
        v64 = 1'b1;
        ab64 = 1'b1;
        #1;
        n_cmp++;
        if (r64 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_iready: got %b required 1", r64);
        end
        @(posedge clk); #1;
        ab64 = 1'b0;
        v64 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== 64'h0) begin
                n_err++;
                $display("FAIL abort_fill_lane%0d: got %h required 0", i, lane64(i));
            end
        end
        // fresh block, then abort while waiting in FULL
        rand_block(17);
        send64();
        ab64 = 1'b1;
        @(posedge clk); #1;
        ab64 = 1'b0;
        n_cmp++;
        if ({full64, r64, lane64(0), lane64(16)} !== {2'b01, 128'h0}) begin
            n_err++;
            $display("FAIL abort_full: full=%b iready=%b lane0=%h lane16=%h required 0 1 0 0", full64, r64, lane64(0), lane64(16));
        end
        // clean block after aborts, abort raised during EMIT must be ignored
        rand_block(17);
        build_model(64);
        send64();
        go64 = 1'b1;
        @(posedge clk); #1;
        go64 = 1'b0;
        ab64 = 1'b1;
        n_cmp++;
        if (smp64 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_emit_sample: got %b required 1", smp64);
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== exp_lane[i]) begin
                n_err++;
                $display("FAIL abort_clean_lane%0d: got %h required %h", i, lane64(i), exp_lane[i]);
            end
        end
        @(posedge clk); #1;
        ab64 = 1'b0;
        n_cmp++;
        if (smp64 !== 1'b0 || r64 !== 1'b1 || lane64(3) !== exp_lane[3]) begin
            n_err++;
            $display("FAIL abort_in_emit: sample=%b iready=%b lane3=%h required 0 1 %h", smp64, r64, lane64(3), exp_lane[3]);
        end
    endtask

    task automatic test_reset_mid();
        rand_block(9);
        go64 = 1'b1;
        send64();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({r64, full64, smp64} !== 3'b000) begin
            n_err++;
            $display("FAIL midreset_ctrl: iready/full/sample=%b required 000", {r64, full64, smp64});
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== 64'h0) begin
                n_err++;
                $display("FAIL midreset_lane%0d: got %h required 0", i, lane64(i));
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rand_block(17);
        build_model(64);
        send64();
        @(posedge clk); #1;
        n_cmp++;
        if (smp64 !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_sample: got %b required 1", smp64);
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (lane64(i) !== exp_lane[i]) begin
                n_err++;
                $display("FAIL midreset_lane_after%0d: got %h required %h", i, lane64(i), exp_lane[i]);
            end
        end
        go64 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random_blocks();
        int dly;
        for (int it = 0; it < 6; it++) begin
            dly = $urandom_range(0, 3);
            if (it % 2 == 0) begin
                rand_block(17);
                build_model(64);
                go64 = 1'b0;
                send64();
                repeat (dly) begin @(posedge clk); #1; end
                go64 = 1'b1;
                @(posedge clk); #1;
                go64 = 1'b0;
                n_cmp++;
                if (smp64 !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand%0d_sample64: got %b required 1", it, smp64);
                end
                for (int i = 0; i < 25; i++) begin
                    n_cmp++;
                    if (lane64(i) !== exp_lane[i]) begin
                        n_err++;
                        $display("FAIL rand%0d_lane64_%0d: got %h required %h", it, i, lane64(i), exp_lane[i]);
                    end
                end
            end else begin
                rand_block(34);
                build_model(32);
                go32 = 1'b0;
                send32();
                repeat (dly) begin @(posedge clk); #1; end
                go32 = 1'b1;
                @(posedge clk); #1;
                go32 = 1'b0;
                n_cmp++;
                if (smp32 !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand%0d_sample32: got %b required 1", it, smp32);
                end
                for (int i = 0; i < 25; i++) begin
                    n_cmp++;
                    if (lane32(i) !== exp_lane[i]) begin
                        n_err++;
                        $display("FAIL rand%0d_lane32_%0d: got %h required %h", it, i, lane32(i), exp_lane[i]);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SHA3_LOADER_BYTESWAP_EN
    task automatic test_byteswap();
        rand_block(17);
        wq[0] = 64'h0102030405060708;
        go64 = 1'b1;
        send64();
        @(posedge clk); #1;
        go64 = 1'b0;
        n_cmp++;
        if (smp64 !== 1'b1 || a64[0] !== 64'h0807060504030201) begin
            n_err++;
            $display("FAIL byteswap: sample=%b osa0=%h required 1 0807060504030201", smp64, a64[0]);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_fill64();
        test_fill32();
        test_go_hold();
        test_abort();
        test_reset_mid();
        test_random_blocks();
`ifdef SHA3_LOADER_BYTESWAP_EN
        test_byteswap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
